// File: rtl/operand_fetch_pkg.sv
// Shared widths and small helpers for the operand-fetch stage.
// Default widths match the standard 32-register, 32-bit configuration.
package operand_fetch_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int IMM_W  = 16;

    function automatic logic signed [DATA_W-1:0] sign_extend(input logic [IMM_W-1:0] imm);
        logic signed [IMM_W-1:0] imm_s;
        imm_s = imm;
        return DATA_W'(imm_s);
    endfunction

    function automatic logic [ADDR_W-1:0] dest_select(input logic          reg_dst,
                                                       input logic [ADDR_W-1:0] rd,
                                                       input logic [ADDR_W-1:0] rt);
        return reg_dst ? rd : rt;
    endfunction

endpackage

// File: rtl/operand_fetch_pipe_regfile_scoreboard.sv
// Register array with write-first forwarded read ports and a per-register busy vector.
// Busy marks a destination owned by an in-flight instruction until its write-back lands.
module regfile_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W   = operand_fetch_pkg::DATA_W,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = operand_fetch_pkg::ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_next;
    logic              wr_en;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_en = wb_valid && !is_zero(wb_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // A same-cycle write-back and read of one index returns the incoming data.
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        if (wb_valid && wb_addr == rd_addr_a) rd_data_a = wb_data;
        if (is_zero(rd_addr_a)) rd_data_a = '0;
        rd_data_b = regs_q[rd_addr_b];
        if (wb_valid && wb_addr == rd_addr_b) rd_data_b = wb_data;
        if (is_zero(rd_addr_b)) rd_data_b = '0;
    end

    assign busy_a = busy_q[rd_addr_a] && !(wb_valid && wb_addr == rd_addr_a) && !is_zero(rd_addr_a);
    assign busy_b = busy_q[rd_addr_b] && !(wb_valid && wb_addr == rd_addr_b) && !is_zero(rd_addr_b);

    // Set is applied after clear so a new owner wins over a retiring one.
    always_comb begin
        busy_next = busy_q;
        if (wb_valid) busy_next[wb_addr] = 1'b0;
        if (set_en && !is_zero(set_addr)) busy_next[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_next;
    end

endmodule

// File: rtl/operand_fetch_pipe.sv
// Operand-fetch stage between decode and execute: RAW-hazard stall, forwarding,
// immediate select and a registered valid/ready output.
module operand_fetch_pipe
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W   = operand_fetch_pkg::DATA_W,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = operand_fetch_pkg::ADDR_W,
    parameter int IMM_W    = operand_fetch_pkg::IMM_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [IMM_W-1:0]  imm,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              RegWrite,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic [ADDR_W-1:0] out_dest,
    output logic              out_regwrite
);

    logic [DATA_W-1:0]        src1_p0;
    logic [DATA_W-1:0]        src2_p0;
    logic signed [DATA_W-1:0] imm_ext_p0;
    logic [DATA_W-1:0]        op2_p0;
    logic [ADDR_W-1:0]        dest_p0;
    logic                     busy1_p0;
    logic                     busy2_p0;
    logic                     accept_p0;

    logic                     vld_p1;
    logic [DATA_W-1:0]        operand1_p1;
    logic [DATA_W-1:0]        operand2_p1;
    logic [ADDR_W-1:0]        dest_p1;
    logic                     regwrite_p1;

    regfile_scoreboard #(
        .DATA_W   (DATA_W),
        .NREGS    (NREGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rd_addr_a (rs),
        .rd_addr_b (rt),
        .rd_data_a (src1_p0),
        .rd_data_b (src2_p0),
        .busy_a    (busy1_p0),
        .busy_b    (busy2_p0),
        .set_en    (accept_p0 && RegWrite),
        .set_addr  (dest_p0)
    );

    // ---- p0: decode-side operand select and hazard check ----
    assign imm_ext_p0 = sign_extend(imm);
    assign op2_p0     = ALUSrc ? imm_ext_p0 : src2_p0;
    assign dest_p0    = dest_select(RegDst, rd, rt);

    // An immediate-form instruction does not depend on rt.
    assign in_ready  = (!vld_p1 || out_ready) && !busy1_p0 && !(busy2_p0 && !ALUSrc);
    assign accept_p0 = in_valid && in_ready;

    // ---- p1: registered output to execute ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            operand1_p1 <= '0;
            operand2_p1 <= '0;
            dest_p1     <= '0;
            regwrite_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1      <= 1'b1;
            operand1_p1 <= src1_p0;
            operand2_p1 <= op2_p0;
            dest_p1     <= dest_p0;
            regwrite_p1 <= RegWrite;
        end else if (out_ready) begin
            vld_p1      <= 1'b0;
        end
    end

    assign out_valid    = vld_p1;
    assign operand1     = operand1_p1;
    assign operand2     = operand2_p1;
    assign out_dest     = dest_p1;
    assign out_regwrite = regwrite_p1;

endmodule

// File: tb/tb_operand_fetch_pipe.sv
// Bench for operand_fetch_pipe: directed scenarios plus randomized traffic
// compared cycle by cycle against an architectural reference model.
module tb_operand_fetch_pipe;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int IMM_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid, in_ready;
    logic [ADDR_W-1:0] rs, rt, rd;
    logic [IMM_W-1:0]  imm;
    logic              RegDst, ALUSrc, RegWrite;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] operand1, operand2;
    logic [ADDR_W-1:0] out_dest;
    logic              out_regwrite;

    operand_fetch_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand1(operand1), .operand2(operand2),
        .out_dest(out_dest), .out_regwrite(out_regwrite)
    );

    always #5 clk = ~clk;

    // Architectural model: register values, pending-write flags, output latch.
    logic [DATA_W-1:0] m_reg [NREGS];
    bit                m_busy [NREGS];
    bit                m_ov, m_rw;
    logic [DATA_W-1:0] m_op1, m_op2;
    logic [ADDR_W-1:0] m_dest;

    int checks   = 0;
    int failures = 0;
    logic obs_ready;
    bit   exp_ready;
    logic [70:0] saved;

    function automatic logic [DATA_W-1:0] m_fwd(input logic [ADDR_W-1:0] idx);
        if (idx == 0) return '0;
        if (wb_valid && wb_addr == idx) return wb_data;
        return m_reg[idx];
    endfunction

    function automatic bit m_ready();
        bit b1, b2;
        b1 = (rs != 0) && m_busy[rs] && !(wb_valid && wb_addr == rs);
        b2 = !ALUSrc && (rt != 0) && m_busy[rt] && !(wb_valid && wb_addr == rt);
        return (!m_ov || out_ready) && !b1 && !b2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_ov = 0; m_rw = 0; m_op1 = '0; m_op2 = '0; m_dest = '0;
    endtask

    task automatic model_edge();
        bit acc;
        logic signed [DATA_W-1:0] se;
        logic [ADDR_W-1:0] dst;
        se  = $signed(imm);
        dst = RegDst ? rd : rt;
        acc = in_valid && m_ready();
        if (acc) begin
            m_op1  = m_fwd(rs);
            m_op2  = ALUSrc ? se : m_fwd(rt);
            m_dest = dst;
            m_rw   = RegWrite;
            m_ov   = 1;
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (wb_valid && wb_addr != 0) begin
            m_reg[wb_addr]  = wb_data;
            m_busy[wb_addr] = 1'b0;
        end
        if (acc && RegWrite && dst != 0) m_busy[dst] = 1'b1;
    endtask

    task automatic idle();
        in_valid = 0; rs = '0; rt = '0; rd = '0; imm = '0;
        RegDst = 0; ALUSrc = 0; RegWrite = 0;
        wb_valid = 0; wb_addr = '0; wb_data = '0; out_ready = 1;
    endtask

    // Advance one clock, sampling in_ready mid-cycle and outputs just after the edge.
    task automatic tick();
        @(negedge clk);
        obs_ready = in_ready;
        exp_ready = m_ready();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        model_reset();
        #3;
        checks++;
        if ({out_valid, operand1, operand2, out_dest, out_regwrite} !== 71'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", {out_valid, operand1, operand2, out_dest, out_regwrite});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b required 1", in_ready);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_basic();
        idle(); wb_valid = 1; wb_addr = 3; wb_data = 32'h33; tick();
        wb_addr = 4; wb_data = 32'h44; tick();
        idle(); in_valid = 1; rs = 3; rt = 4; tick();
        checks++;
        if (out_valid !== 1'b1 || operand1 !== 32'h33 || operand2 !== 32'h44 || out_regwrite !== 1'b0) begin
            failures++;
            $display("FAIL basic_read: got v=%b op1=%h op2=%h rw=%b required v=1 op1=33 op2=44 rw=0",
                     out_valid, operand1, operand2, out_regwrite);
        end
        idle(); tick();
        checks++;
        if (out_valid !== 1'b0 || operand1 !== 32'h33) begin
            failures++;
            $display("FAIL basic_drain: got v=%b op1=%h required v=0 op1=33", out_valid, operand1);
        end
    endtask

    task automatic test_imm_hazard();
        idle(); in_valid = 1; rs = 1; ALUSrc = 1; imm = 16'hFFFE; RegDst = 0; rt = 7; rd = 2; RegWrite = 1;
        tick();
        checks++;
        if (operand2 !== 32'hFFFF_FFFE || out_dest !== 5'd7 || out_regwrite !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL imm_sext: got op2=%h dest=%0d rw=%b v=%b required op2=fffffffe dest=7 rw=1 v=1",
                     operand2, out_dest, out_regwrite, out_valid);
        end
        idle(); in_valid = 1; rs = 7; ALUSrc = 1; imm = 16'h0001;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs_ready !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL raw_stall: got ready=%b v=%b required ready=0 v=0", obs_ready, out_valid);
            end
        end
        wb_valid = 1; wb_addr = 7; wb_data = 32'h1234;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || out_valid !== 1'b1 || operand1 !== 32'h1234 || operand2 !== 32'h1) begin
            failures++;
            $display("FAIL raw_release: got ready=%b v=%b op1=%h op2=%h required ready=1 v=1 op1=1234 op2=1",
                     obs_ready, out_valid, operand1, operand2);
        end
        idle(); tick();
    endtask

    task automatic test_forward();
        idle(); wb_valid = 1; wb_addr = 5; wb_data = 32'hAA; in_valid = 1; rs = 5; rt = 5;
        tick();
        checks++;
        if (operand1 !== 32'hAA || operand2 !== 32'hAA || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_fwd: got op1=%h op2=%h v=%b required op1=aa op2=aa v=1", operand1, operand2, out_valid);
        end
        idle(); tick();
    endtask

    task automatic test_zero_reg();
        idle(); wb_valid = 1; wb_addr = 0; wb_data = 32'hDEAD;
        in_valid = 1; rs = 0; RegDst = 1; rd = 0; RegWrite = 1;
        tick();
        checks++;
        if (operand1 !== 32'h0) begin
            failures++;
            $display("FAIL zero_fwd: got op1=%h required 0", operand1);
        end
        idle(); in_valid = 1; rs = 0; rt = 0;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || operand1 !== 32'h0 || operand2 !== 32'h0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL zero_read: got ready=%b op1=%h op2=%h v=%b required ready=1 op1=0 op2=0 v=1",
                     obs_ready, operand1, operand2, out_valid);
        end
        idle(); tick();
    endtask

    task automatic test_backpressure();
        idle(); in_valid = 1; rs = 3; rt = 3; tick();
        saved = {out_valid, operand1, operand2, out_dest, out_regwrite};
        out_ready = 0; rs = 4; rt = 4;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_ready !== 1'b0 || {out_valid, operand1, operand2, out_dest, out_regwrite} !== saved
                || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_hold: got ready=%b out=%h required ready=0 out=%h",
                         obs_ready, {out_valid, operand1, operand2, out_dest, out_regwrite}, saved);
            end
        end
        out_ready = 1;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || out_valid !== 1'b1 || operand1 !== 32'h44) begin
            failures++;
            $display("FAIL backpressure_release: got ready=%b v=%b op1=%h required ready=1 v=1 op1=44",
                     obs_ready, out_valid, operand1);
        end
        idle(); tick();
    endtask

    task automatic test_reset_mid_stall();
        idle(); wb_valid = 1; wb_addr = 9; wb_data = 32'h99;
        in_valid = 1; rs = 1; RegDst = 1; rd = 9; RegWrite = 1;
        tick();
        idle(); out_ready = 0; tick();
        checks++;
        if (out_valid !== 1'b1 || out_dest !== 5'd9) begin
            failures++;
            $display("FAIL stall_setup: got v=%b dest=%0d required v=1 dest=9", out_valid, out_dest);
        end
        rst = 1;
        #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || out_regwrite !== 1'b0 || out_dest !== 5'd0) begin
            failures++;
            $display("FAIL async_reset: got v=%b rw=%b dest=%0d required v=0 rw=0 dest=0", out_valid, out_regwrite, out_dest);
        end
        @(posedge clk); #1;
        rst = 0;
        idle(); in_valid = 1; rs = 9; rt = 9;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || out_valid !== 1'b1 || operand1 !== 32'h0 || operand2 !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_read: got ready=%b v=%b op1=%h op2=%h required ready=1 v=1 op1=0 op2=0",
                     obs_ready, out_valid, operand1, operand2);
        end
        idle(); tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            rs        = ADDR_W'($urandom_range(0, 7));
            rt        = ADDR_W'($urandom_range(0, 7));
            rd        = ADDR_W'($urandom_range(0, 7));
            imm       = IMM_W'($urandom);
            RegDst    = 1'($urandom);
            ALUSrc    = 1'($urandom);
            RegWrite  = 1'($urandom);
            wb_valid  = ($urandom_range(0, 1) != 0);
            wb_addr   = ADDR_W'($urandom_range(0, 7));
            wb_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (obs_ready !== exp_ready) begin
                failures++;
                if (errs++ < 10) $display("FAIL rand_ready[%0d]: got %b required %b", n, obs_ready, exp_ready);
            end
            checks++;
            if ({out_valid, operand1, operand2, out_dest, out_regwrite} !== {m_ov, m_op1, m_op2, m_dest, m_rw}) begin
                failures++;
                if (errs++ < 10)
                    $display("FAIL rand_out[%0d]: got v=%b op1=%h op2=%h d=%0d rw=%b required v=%b op1=%h op2=%h d=%0d rw=%b",
                             n, out_valid, operand1, operand2, out_dest, out_regwrite, m_ov, m_op1, m_op2, m_dest, m_rw);
            end
        end
        idle(); tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_imm_hazard();
        test_forward();
        test_zero_reg();
        test_backpressure();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
